ch_trigger_stop_ctrl: RTL

- Per-channel stage directly downstream of the channel trigger generator. Consumes its `trigger` output.
- Synchronises `trigger` into FCLK, detects its rising edge, latches the sample write pointer at the trigger instant, counts a programmable post-trigger delay, then stops sampling.
- Holds the channel stopped until readout completes.

---
 rtl/ch_trigger_stop_ctrl_if.sv | 28 ++
 rtl/ch_trigger_stop_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/ch_trigger_stop_ctrl_if.sv
// Channel trigger/stop bundle: trigger and sampling controls in, capture status out.
// The slave side is the per-channel stop controller.
interface ch_trigger_stop_ctrl_if #(
  parameter int PTR_W = 8,
  parameter int DLY_W = 8
);
  logic             trigger;
  logic             ARM;
  logic [PTR_W-1:0] SAMPLE_PTR;
  logic [DLY_W-1:0] STOP_DELAY;
  logic             READOUT_DONE;
  logic             sampling_en;
  logic             stop_req;
  logic             stopped;
  logic [PTR_W-1:0] trig_ptr;
  logic             trig_valid;
  logic             trig_missed;

  modport master (
    output trigger, ARM, SAMPLE_PTR, STOP_DELAY, READOUT_DONE,
    input  sampling_en, stop_req, stopped, trig_ptr, trig_valid, trig_missed
  );

  modport slave (
    input  trigger, ARM, SAMPLE_PTR, STOP_DELAY, READOUT_DONE,
    output sampling_en, stop_req, stopped, trig_ptr, trig_valid, trig_missed
  );
endinterface

// File: rtl/ch_trigger_stop_ctrl.sv
// Per-channel trigger capture and post-trigger stop controller.
// Synchronises trigger, latches the write pointer and stops sampling after a delay.
module ch_trigger_stop_ctrl #(
  parameter int PTR_W       = 8,
  parameter int DLY_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    FCLK,
  input  logic                    INST_START,
  ch_trigger_stop_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARMED, POST_TRIG, STOPPED} state_t;

  state_t           state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             edge_q;
  logic             trig_edge;
  logic [DLY_W-1:0] cnt;
  logic             sampling_en_q, stop_req_q, stopped_q, trig_valid_q, trig_missed_q;
  logic [PTR_W-1:0] trig_ptr_q;

  always_ff @(posedge FCLK or posedge INST_START) begin
    if (INST_START) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.trigger};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign trig_edge = sync_q[SYNC_STAGES-1] & ~edge_q;

  // The pointer has advanced SYNC_STAGES times since the trigger was first sampled.
  always_ff @(posedge FCLK or posedge INST_START) begin
    if (INST_START) begin
      state         <= IDLE;
      cnt           <= '0;
      sampling_en_q <= 1'b0;
      stop_req_q    <= 1'b0;
      stopped_q     <= 1'b0;
      trig_valid_q  <= 1'b0;
      trig_missed_q <= 1'b0;
      trig_ptr_q    <= '0;
    end else begin
      stop_req_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ARM) begin
            state         <= ARMED;
            sampling_en_q <= 1'b1;
            trig_valid_q  <= 1'b0;
            trig_missed_q <= 1'b0;
            trig_ptr_q    <= '0;
          end
        end
        ARMED: begin
          if (trig_edge) begin
            trig_ptr_q   <= bus.SAMPLE_PTR - PTR_W'(SYNC_STAGES);
            trig_valid_q <= 1'b1;
            if (bus.STOP_DELAY == '0) begin
              state         <= STOPPED;
              sampling_en_q <= 1'b0;
              stopped_q     <= 1'b1;
              stop_req_q    <= 1'b1;
            end else begin
              cnt   <= bus.STOP_DELAY - DLY_W'(1);
              state <= POST_TRIG;
            end
          end else if (!bus.ARM) begin
            state         <= IDLE;
            sampling_en_q <= 1'b0;
          end
        end
        POST_TRIG: begin
          if (trig_edge) trig_missed_q <= 1'b1;
          if (cnt == '0) begin
            state         <= STOPPED;
            sampling_en_q <= 1'b0;
            stopped_q     <= 1'b1;
            stop_req_q    <= 1'b1;
          end else begin
            cnt <= cnt - DLY_W'(1);
          end
        end
        STOPPED: begin
          if (trig_edge) trig_missed_q <= 1'b1;
          if (bus.READOUT_DONE) begin
            state     <= IDLE;
            stopped_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sampling_en = sampling_en_q;
  assign bus.stop_req    = stop_req_q;
  assign bus.stopped     = stopped_q;
  assign bus.trig_ptr    = trig_ptr_q;
  assign bus.trig_valid  = trig_valid_q;
  assign bus.trig_missed = trig_missed_q;

endmodule
